// File: rtl/tff_bank_arbiter_pkg.sv
// Shared types and helpers for the round-robin T flip-flop bank arbiter.
package tff_bank_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_MAX_HOLD = 4;

    // (a + b) mod n for operands already in [0, n)
    function automatic int rr_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/tff_bank_arbiter_if.sv
// Request/grant bundle between toggle clients and the shared T flip-flop bank arbiter.
interface tff_bank_arbiter_if #(
    parameter int N_REQ = tff_bank_arbiter_pkg::DEF_N_REQ,
    parameter int WIDTH = tff_bank_arbiter_pkg::DEF_WIDTH
);
    localparam int OW = $clog2(N_REQ);

    logic                   clr;
    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       lock;
    logic [N_REQ*WIDTH-1:0] mask;
    logic [N_REQ-1:0]       gnt;
    logic [OW-1:0]          owner;
    logic                   busy;
    logic [WIDTH-1:0]       q;

    modport master (output clr, req, lock, mask, input gnt, owner, busy, q);
    modport slave  (input clr, req, lock, mask, output gnt, owner, busy, q);
endinterface

// File: rtl/tff_bank_arbiter_bank.sv
// WIDTH-bit T flip-flop register: q ^= t when en, sync clear wins over toggle.
// Latency 1 cycle; no backpressure.
module tff_bank_arbiter_bank #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q ^ t;
        end
    end
endmodule

// File: rtl/tff_bank_arbiter.sv
// Round-robin arbiter applying one requester's toggle mask per cycle, with bounded lock bursts.
// Latency: req at edge n -> q/gnt visible cycle n+1; no backpressure, losers simply keep requesting.
module tff_bank_arbiter
    import tff_bank_arbiter_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic               clk,
    input  logic               rst,
    tff_bank_arbiter_if.slave  bus
);
    localparam int PW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);

    state_t           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    owner_q, owner_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [PW-1:0]    cand, scan_idx, sel_idx;
    logic             scan_vld, apply;
    logic [WIDTH-1:0] sel_mask;

    // Descending walk so the candidate closest to ptr is the last one written.
    always_comb begin
        scan_vld = 1'b0;
        scan_idx = '0;
        cand     = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            cand = PW'(rr_add(int'(ptr_q), j, N_REQ));
            if (bus.req[cand]) begin
                scan_vld = 1'b1;
                scan_idx = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        gnt_d   = '0;
        apply   = 1'b0;
        sel_idx = owner_q;
        if (bus.clr) begin
            state_d = ST_IDLE;
            hold_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_vld) begin
                        apply   = 1'b1;
                        sel_idx = scan_idx;
                        gnt_d   = N_REQ'(1) << scan_idx;
                        owner_d = scan_idx;
                        ptr_d   = PW'(rr_add(int'(scan_idx), 1, N_REQ));
                        if (bus.lock[scan_idx] && (MAX_HOLD > 1)) begin
                            state_d = ST_OWNED;
                            hold_d  = HW'(1);
                        end
                    end
                end
                ST_OWNED: begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                    if (bus.req[owner_q]) begin
                        apply = 1'b1;
                        gnt_d = N_REQ'(1) << owner_q;
                        if (bus.lock[owner_q] && ((hold_q + HW'(1)) != HW'(MAX_HOLD))) begin
                            state_d = ST_OWNED;
                            hold_d  = hold_q + HW'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel_idx == PW'(i)) begin
                sel_mask = bus.mask[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
        end
    end

    tff_bank_arbiter_bank #(.WIDTH(WIDTH)) u_bank (
        .clk (clk),
        .rst (rst),
        .clr (bus.clr),
        .en  (apply),
        .t   (sel_mask),
        .q   (bus.q)
    );

    assign bus.gnt   = gnt_q;
    assign bus.owner = owner_q;
    assign bus.busy  = (state_q == ST_OWNED);
endmodule

// File: tb/tb_tff_bank_arbiter.sv
// Bench for tff_bank_arbiter: directed vector table, mid-cycle reset sequence, random run vs model.
module tb_tff_bank_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    tff_bank_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    tff_bank_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [31:0] mask;
        logic [7:0]  q;
        logic [3:0]  gnt;
        logic [1:0]  own;
        logic        busy;
    } vec_t;

    vec_t tbl[21];

    // Reference: q, the rotating pointer, and the length of the current locked burst.
    logic [7:0] m_q;
    logic [3:0] m_gnt;
    int         m_ptr, m_owner, m_burst;
    bit         m_owned;

    function automatic vec_t mkv(input logic c, input logic [3:0] rq, input logic [3:0] lk,
                                 input logic [31:0] mk, input logic [7:0] eq, input logic [3:0] eg,
                                 input logic [1:0] eo, input logic eb);
        vec_t v;
        v.clr = c; v.req = rq; v.lock = lk; v.mask = mk;
        v.q = eq; v.gnt = eg; v.own = eo; v.busy = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic [3:0] rq, input logic [3:0] lk, input logic [31:0] mk);
        bus.clr  = c;
        bus.req  = rq;
        bus.lock = lk;
        bus.mask = mk;
    endtask

    task automatic model_reset();
        m_q = '0; m_gnt = '0; m_ptr = 0; m_owner = 0; m_burst = 0; m_owned = 1'b0;
    endtask

    task automatic model_step(input logic c, input logic [3:0] rq, input logic [3:0] lk, input logic [31:0] mk);
        bit found;
        m_gnt = '0;
        if (c) begin
            m_q = '0; m_owned = 1'b0; m_burst = 0;
        end else if (m_owned) begin
            if (rq[m_owner]) begin
                m_q   = m_q ^ mk[m_owner*8 +: 8];
                m_gnt = 4'(1 << m_owner);
                m_burst++;
                if (!lk[m_owner] || m_burst == MAX_HOLD) m_owned = 1'b0;
            end else begin
                m_owned = 1'b0;
            end
        end else begin
            found = 1'b0;
            for (int j = 0; j < N; j++) begin
                int k;
                k = (m_ptr + j) % N;
                if (!found && rq[k]) begin
                    found   = 1'b1;
                    m_q     = m_q ^ mk[k*8 +: 8];
                    m_gnt   = 4'(1 << k);
                    m_owner = k;
                    m_ptr   = (k + 1) % N;
                    if (lk[k] && MAX_HOLD > 1) begin
                        m_owned = 1'b1;
                        m_burst = 1;
                    end
                end
            end
        end
    endtask

    initial begin
        tbl[0]  = mkv(0, 4'hF, 4'h0, 32'h08040201, 8'h01, 4'h1, 2'd0, 0);
        tbl[1]  = mkv(0, 4'hF, 4'h0, 32'h08040201, 8'h03, 4'h2, 2'd1, 0);
        tbl[2]  = mkv(0, 4'hF, 4'h0, 32'h08040201, 8'h07, 4'h4, 2'd2, 0);
        tbl[3]  = mkv(0, 4'hF, 4'h0, 32'h08040201, 8'h0F, 4'h8, 2'd3, 0);
        tbl[4]  = mkv(1, 4'h0, 4'h0, 32'h00000000, 8'h00, 4'h0, 2'd3, 0);
        tbl[5]  = mkv(0, 4'h1, 4'h0, 32'h0000000F, 8'h0F, 4'h1, 2'd0, 0);
        tbl[6]  = mkv(0, 4'h1, 4'h0, 32'h0000000F, 8'h00, 4'h1, 2'd0, 0);
        tbl[7]  = mkv(0, 4'h6, 4'h2, 32'h00018000, 8'h80, 4'h2, 2'd1, 1);
        tbl[8]  = mkv(0, 4'h6, 4'h2, 32'h00018000, 8'h00, 4'h2, 2'd1, 1);
        tbl[9]  = mkv(0, 4'h6, 4'h2, 32'h00018000, 8'h80, 4'h2, 2'd1, 1);
        tbl[10] = mkv(0, 4'h6, 4'h2, 32'h00018000, 8'h00, 4'h2, 2'd1, 0);
        tbl[11] = mkv(0, 4'h6, 4'h2, 32'h00018000, 8'h01, 4'h4, 2'd2, 0);
        tbl[12] = mkv(0, 4'h9, 4'h0, 32'h20000010, 8'h21, 4'h8, 2'd3, 0);
        tbl[13] = mkv(0, 4'h9, 4'h0, 32'h20000010, 8'h31, 4'h1, 2'd0, 0);
        tbl[14] = mkv(1, 4'h1, 4'h0, 32'h000000FF, 8'h00, 4'h0, 2'd0, 0);
        tbl[15] = mkv(0, 4'h1, 4'h0, 32'h000000FF, 8'hFF, 4'h1, 2'd0, 0);
        tbl[16] = mkv(0, 4'h4, 4'h0, 32'h00000000, 8'hFF, 4'h4, 2'd2, 0);
        tbl[17] = mkv(0, 4'h0, 4'h0, 32'h00000000, 8'hFF, 4'h0, 2'd2, 0);
        tbl[18] = mkv(0, 4'h8, 4'h8, 32'h01000000, 8'hFE, 4'h8, 2'd3, 1);
        tbl[19] = mkv(0, 4'h0, 4'h0, 32'h00000000, 8'hFE, 4'h0, 2'd3, 0);
        tbl[20] = mkv(0, 4'h1, 4'h0, 32'h00000002, 8'hFC, 4'h1, 2'd0, 0);

        drive(0, 4'h0, 4'h0, 32'h0);
        #12;
        chk("reset_q", 32'(bus.q), 32'h0);
        chk("reset_gnt", 32'(bus.gnt), 32'h0);
        chk("reset_owner", 32'(bus.owner), 32'h0);
        chk("reset_busy", 32'(bus.busy), 32'h0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].clr, tbl[i].req, tbl[i].lock, tbl[i].mask);
            @(posedge clk); #1;
            chk($sformatf("row%0d_q", i), 32'(bus.q), 32'(tbl[i].q));
            chk($sformatf("row%0d_gnt", i), 32'(bus.gnt), 32'(tbl[i].gnt));
            chk($sformatf("row%0d_owner", i), 32'(bus.owner), 32'(tbl[i].own));
            chk($sformatf("row%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
        end

        // Load q=A5 under a locked owner 2, then reset between edges.
        drive(1, 4'h0, 4'h0, 32'h0);
        @(posedge clk); #1;
        drive(0, 4'h4, 4'h4, 32'h00A50000);
        @(posedge clk); #1;
        chk("prerst_q", 32'(bus.q), 32'hA5);
        chk("prerst_busy", 32'(bus.busy), 32'h1);
        drive(0, 4'h0, 4'h0, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_q", 32'(bus.q), 32'h0);
        chk("midrst_gnt", 32'(bus.gnt), 32'h0);
        chk("midrst_owner", 32'(bus.owner), 32'h0);
        chk("midrst_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 4'hF, 4'h0, 32'h0);
        @(posedge clk); #1;
        chk("postrst_ptr_gnt", 32'(bus.gnt), 32'h1);

        rst = 1'b1;
        drive(0, 4'h0, 4'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 400; c++) begin
            logic        r_clr;
            logic [3:0]  r_req, r_lock;
            logic [31:0] r_mask;
            r_clr  = ($urandom_range(15) == 0);
            r_req  = 4'($urandom_range(15));
            r_lock = 4'($urandom_range(15)) | 4'($urandom_range(15));
            r_mask = $urandom;
            drive(r_clr, r_req, r_lock, r_mask);
            model_step(r_clr, r_req, r_lock, r_mask);
            @(posedge clk); #1;
            chk($sformatf("rnd%0d_q", c), 32'(bus.q), 32'(m_q));
            chk($sformatf("rnd%0d_gnt", c), 32'(bus.gnt), 32'(m_gnt));
            chk($sformatf("rnd%0d_owner", c), 32'(bus.owner), 32'(m_owner));
            chk($sformatf("rnd%0d_busy", c), 32'(bus.busy), 32'(m_owned));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
